burst_mem_responder: RTL
========================

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning idle cycles from request accept to first resp_o beat (legal 1..15).
REQ-002 SHALL have parameter LINES, default 256, meaning number of 256-bit lines stored (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port address_i  input  32  byte address of the burst.
REQ-006 SHALL have port read_i  input  1  read-burst request, held by initiator until first resp_o.
REQ-007 SHALL have port write_i  input  1  write-burst request, held by initiator until last resp_o.
REQ-008 SHALL have port burst_i  input  64  write beat k, held by initiator until resp_o acknowledges it.
REQ-009 SHALL have port burst_o  output  64  read beat data, valid when resp_o=1 in a read burst.
REQ-010 SHALL have port resp_o  output  1  one pulse per beat, 4 per burst.
REQ-011 SHALL have port busy_o  output  1  1 in every state except IDLE.
REQ-012 SHALL have port err_o  output  1  sticky protocol-error flag.
REQ-013 SHALL have ports rd_count_o and wr_count_o  output  32 each  completed read/write bursts.

Function
REQ-014 SHALL implement states IDLE, WAIT, BEAT, TURN.
REQ-015 SHALL accept a request only in IDLE; on accept latch line index = address_i[5+log2(LINES)-1:5] and direction, load latency counter with LATENCY, go to WAIT.
REQ-016 SHALL ignore address_i[4:0] (align down) and bits above the index (aliasing); nonzero address_i[4:0] at accept sets err_o.
REQ-017 SHALL, when read_i and write_i are both 1 in IDLE, accept neither, set err_o, stay IDLE.
REQ-018 SHALL decrement the latency counter each WAIT cycle and enter BEAT when it reaches 0, giving first resp_o exactly LATENCY+1 cycles after the accept edge.
REQ-019 SHALL in BEAT assert resp_o for 4 consecutive cycles, beat counter k = 0,1,2,3, no gaps.
REQ-020 SHALL on read drive burst_o = line[64k+63:64k] in the same cycle resp_o is high for beat k.
REQ-021 SHALL on write store burst_i into line[64k+63:64k] at the edge ending the cycle resp_o is high for beat k.
REQ-022 SHALL drive burst_o = 0 whenever resp_o = 0.
REQ-023 SHALL after beat 3 enter TURN for exactly one cycle (no accept, resp_o=0), then IDLE.
REQ-024 SHALL increment rd_count_o/wr_count_o at the edge leaving beat 3; counters wrap 0xFFFF_FFFF -> 0.
REQ-025 SHALL not sample read_i/write_i/address_i after accept; changes mid-burst do not alter the burst.
REQ-026 SHALL give a read of a line written by an immediately preceding burst the new data (write-then-read coherent).

Reset
REQ-027 SHALL on reset_n=0 at a clock edge force state IDLE, resp_o=0, burst_o=0, busy_o=0, err_o=0, counters 0, latency and beat counters 0.
REQ-028 SHALL on reset mid-burst abort with no further resp_o; beats already written remain; storage contents are never cleared by reset.
REQ-029 SHALL accept a request present in the first cycle with reset_n=1.

Structure
REQ-030 SHALL place the state enum, BEATS_PER_LINE=4, BEAT_W=64, LINE_W=256 in rv32i_types.
REQ-031 SHALL use one sub-module line_store: LINES x 4 x 64-bit array, one beat read (combinational) and one beat write port, beat-select input.
REQ-032 SHALL keep FSM, counters and error logic in burst_mem_responder.

Verification
REQ-033 SHALL cover: write 0x0000_0040 beats {A0,A1,A2,A3} with LATENCY=4 -> resp_o at cycles 5..8 after accept, then read 0x40 -> burst_o A0..A3 in order at cycles 5..8, rd_count_o=1, wr_count_o=1.
REQ-034 SHALL cover: read_i and write_i both 1 in IDLE -> no resp_o for 20 cycles, err_o=1, busy_o=0.
REQ-035 SHALL cover: read of 0x0000_0047 -> data of line 0x40 returned, err_o=1; address 0x0000_2040 with LINES=256 -> aliases line 0x40.
REQ-036 SHALL cover: reset_n=0 during beat 2 of write to 0x80 -> resp_o=0 next cycle, later read of 0x80 shows new beats 0,1 and old beats 2,3.
REQ-037 SHALL cover: back-to-back requests held continuously -> exactly one TURN cycle between last beat and next accept, 4 resp_o per burst, never 5.
REQ-038 SHALL cover: counters preloaded by 2^32-1 completed reads (forced) -> next read completion gives rd_count_o=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and sizes for the burst memory responder.
package rv32i_types;

    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_W         = 64;
    localparam int LINE_W         = 256;
    localparam int BEAT_IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2,
        ST_TURN = 2'd3
    } state_e;

endpackage

// File: rtl/burst_mem_responder_line_store.sv
// Line storage: LINES lines of four 64-bit beats.
// One combinational beat read and one clocked beat write, both addressed
// by the same line index and beat select. Contents are never reset.
module line_store
    import rv32i_types::*;
#(
    parameter int LINES = 256,
    localparam int IDX_W = $clog2(LINES)
)(
    input  logic                  clk,
    input  logic [IDX_W-1:0]      i_line,
    input  logic [BEAT_IDX_W-1:0] i_beat,
    input  logic                  i_wr_en,
    input  logic [BEAT_W-1:0]     i_wr_data,
    output logic [BEAT_W-1:0]     o_rd_data
);

    logic [BEAT_W-1:0] r_mem [LINES][BEATS_PER_LINE];

    // Write one beat at the edge that ends its response cycle.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_line][i_beat] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_line][i_beat];

endmodule

// File: rtl/burst_mem_responder.sv
// Fixed-length (4-beat) burst memory responder with programmable latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; the only state that samples inputs
// WAIT  | latency countdown after accept
// BEAT  | one resp_o pulse per cycle, beat k = 0..3
// TURN  | single dead cycle after the last beat
module burst_mem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY = 4,
    parameter int LINES   = 256
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic              resp_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
);

    localparam int         IDX_W    = $clog2(LINES);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [3:0]            r_lat;
    logic [3:0]            w_lat_nxt;
    logic [BEAT_IDX_W-1:0] r_beat;
    logic [BEAT_IDX_W-1:0] w_beat_nxt;
    logic [IDX_W-1:0]      r_line;
    logic [IDX_W-1:0]      w_line_nxt;
    logic                  r_is_rd;
    logic                  w_is_rd_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [31:0]           r_rd_count;
    logic [31:0]           w_rd_count_nxt;
    logic [31:0]           r_wr_count;
    logic [31:0]           w_wr_count_nxt;
    logic                  w_resp;
    logic                  w_wr_en;
    logic [BEAT_W-1:0]     w_rd_data;
    logic                  w_unused_addr;

    // Address bits above the line index alias onto the same line.
    assign w_unused_addr = ^address_i[31:5+IDX_W];

    // Register all control state; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_lat      <= '0;
            r_beat     <= '0;
            r_line     <= '0;
            r_is_rd    <= 1'b0;
            r_err      <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat      <= w_lat_nxt;
            r_beat     <= w_beat_nxt;
            r_line     <= w_line_nxt;
            r_is_rd    <= w_is_rd_nxt;
            r_err      <= w_err_nxt;
            r_rd_count <= w_rd_count_nxt;
            r_wr_count <= w_wr_count_nxt;
        end
    end

    // Next-state, counters and error flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat;
        w_beat_nxt     = r_beat;
        w_line_nxt     = r_line;
        w_is_rd_nxt    = r_is_rd;
        w_err_nxt      = r_err;
        w_rd_count_nxt = r_rd_count;
        w_wr_count_nxt = r_wr_count;
        w_resp         = 1'b0;
        w_wr_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (read_i && write_i) begin
                    w_err_nxt = 1'b1;
                end else if (read_i || write_i) begin
                    w_state_nxt = ST_WAIT;
                    w_lat_nxt   = LAT_LOAD;
                    w_beat_nxt  = '0;
                    w_line_nxt  = address_i[5 +: IDX_W];
                    w_is_rd_nxt = read_i;
                    if (address_i[4:0] != 5'd0) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                w_lat_nxt = r_lat - 4'd1;
                if (r_lat <= 4'd1) begin
                    w_lat_nxt   = '0;
                    w_state_nxt = ST_BEAT;
                end
            end
            ST_BEAT: begin
                w_resp     = 1'b1;
                w_wr_en    = !r_is_rd;
                w_beat_nxt = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_nxt = ST_TURN;
                    if (r_is_rd) begin
                        w_rd_count_nxt = r_rd_count + 32'd1;
                    end else begin
                        w_wr_count_nxt = r_wr_count + 32'd1;
                    end
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A reset edge landing on a beat must not commit that beat.
    line_store #(.LINES(LINES)) u_line_store (
        .clk       (clk),
        .i_line    (r_line),
        .i_beat    (r_beat),
        .i_wr_en   (w_wr_en && reset_n),
        .i_wr_data (burst_i),
        .o_rd_data (w_rd_data)
    );

    assign resp_o     = w_resp;
    assign burst_o    = (w_resp && r_is_rd) ? w_rd_data : '0;
    assign busy_o     = (r_state != ST_IDLE);
    assign err_o      = r_err;
    assign rd_count_o = r_rd_count;
    assign wr_count_o = r_wr_count;

endmodule
